// File: rtl/gate_array_sampler.sv
// Gate-array sampler: applies a selectable bitwise gate to a CHANNELS x WIDTH operand array,
// converts the 4-state result to 2-state (X/Z -> 0), buffers it in a 2-entry FIFO and keeps a history.
module gate_array_sampler #(
    parameter int CHANNELS = 3,
    parameter int WIDTH    = 2,
    parameter int DEPTH    = 4,
    parameter int CNT_W    = 8
) (
    input  logic                                     clk,
    input  logic                                     rst_n,
    input  logic                                     in_valid,
    output logic                                     in_ready,
    input  logic [1:0]                               mode,
    input  logic [CHANNELS-1:0][WIDTH-1:0]           a,
    input  logic [CHANNELS-1:0][WIDTH-1:0]           b,
    output logic                                     out_valid,
    input  logic                                     out_ready,
    output bit   [CHANNELS-1:0][WIDTH-1:0]           out_data,
    output bit   [DEPTH-1:0][CHANNELS-1:0][WIDTH-1:0] hist,
    output logic [CNT_W-1:0]                         xz_count,
    output logic                                     xz_seen
);

    localparam int N = CHANNELS * WIDTH;

    typedef bit [CHANNELS-1:0][WIDTH-1:0] word_t;

    logic [N-1:0] raw;
    bit   [N-1:0] conv_flat;
    word_t        conv;
    logic         unk;
    logic         push;
    logic         pop;

    logic [1:0]                        occ_q, occ_d;
    word_t                             slot0_q, slot0_d;
    word_t                             slot1_q, slot1_d;
    bit   [DEPTH-1:0][CHANNELS-1:0][WIDTH-1:0] hist_q, hist_d;
    logic [CNT_W-1:0]                  xz_count_q, xz_count_d;
    logic                              xz_seen_q, xz_seen_d;

    // Gate evaluation keeps 4-state semantics so unknowns can be detected before conversion.
    always_comb begin
        raw = '0;
        case (mode)
            2'b00:   raw = a | b;
            2'b01:   raw = a & b;
            2'b10:   raw = a ^ b;
            default: raw = ~a;
        endcase
        unk = $isunknown(raw);
        conv_flat = '0;
        for (int i = 0; i < N; i++) begin
            conv_flat[i] = (raw[i] === 1'b1);
        end
        conv = word_t'(conv_flat);
    end

    assign in_ready  = (occ_q != 2'd2);
    assign out_valid = (occ_q != 2'd0);
    assign out_data  = slot0_q;
    assign hist      = hist_q;
    assign xz_count  = xz_count_q;
    assign xz_seen   = xz_seen_q;

    assign push = in_valid && in_ready;
    assign pop  = out_valid && out_ready;

    // slot0 is always the head; on a pop from a full buffer slot1 shifts forward.
    always_comb begin
        occ_d   = occ_q;
        slot0_d = slot0_q;
        slot1_d = slot1_q;
        case (occ_q)
            2'd0: begin
                if (push) begin
                    slot0_d = conv;
                    occ_d   = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    slot0_d = conv;
                end else if (push) begin
                    slot1_d = conv;
                    occ_d   = 2'd2;
                end else if (pop) begin
                    occ_d   = 2'd0;
                end
            end
            default: begin
                if (pop) begin
                    slot0_d = slot1_q;
                    occ_d   = 2'd1;
                end
            end
        endcase
    end

    always_comb begin
        hist_d     = hist_q;
        xz_count_d = xz_count_q;
        xz_seen_d  = xz_seen_q;
        if (push) begin
            hist_d[0] = conv;
            for (int i = 1; i < DEPTH; i++) begin
                hist_d[i] = hist_q[i-1];
            end
            if (unk) begin
                xz_seen_d = 1'b1;
                if (xz_count_q != {CNT_W{1'b1}}) begin
                    xz_count_d = xz_count_q + 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            occ_q      <= 2'd0;
            slot0_q    <= '0;
            slot1_q    <= '0;
            hist_q     <= '0;
            xz_count_q <= '0;
            xz_seen_q  <= 1'b0;
        end else begin
            occ_q      <= occ_d;
            slot0_q    <= slot0_d;
            slot1_q    <= slot1_d;
            hist_q     <= hist_d;
            xz_count_q <= xz_count_d;
            xz_seen_q  <= xz_seen_d;
        end
    end

endmodule

// File: tb/tb_gate_array_sampler.sv
// Bench for gate_array_sampler: scenario tasks plus a negedge scoreboard tracking accepts and pops.
module tb_gate_array_sampler;

    localparam int CHANNELS = 3;
    localparam int WIDTH    = 2;
    localparam int DEPTH    = 4;
    localparam int CNT_W    = 2;
    localparam int N        = CHANNELS * WIDTH;

    typedef logic [CHANNELS-1:0][WIDTH-1:0] vec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [1:0] mode_i = 2'b00;
    vec_t       a_i = '0;
    vec_t       b_i = '0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    bit   [CHANNELS-1:0][WIDTH-1:0]            out_data;
    bit   [DEPTH-1:0][CHANNELS-1:0][WIDTH-1:0] hist;
    logic [CNT_W-1:0] xz_count;
    logic             xz_seen;

    int cmp_count  = 0;
    int fail_count = 0;

    logic [N-1:0]       exp_q[$];
    logic [DEPTH*N-1:0] m_hist = '0;
    logic [CNT_W-1:0]   m_xz_count = '0;
    logic               m_xz_seen = 1'b0;

    gate_array_sampler #(
        .CHANNELS(CHANNELS), .WIDTH(WIDTH), .DEPTH(DEPTH), .CNT_W(CNT_W)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .mode(mode_i), .a(a_i), .b(b_i),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .hist(hist), .xz_count(xz_count), .xz_seen(xz_seen)
    );

    always #5 clk = ~clk;

    function automatic logic [N-1:0] raw_of(input logic [1:0] m, input vec_t x, input vec_t y);
        logic [N-1:0] fx, fy, r;
        fx = x;
        fy = y;
        for (int i = 0; i < N; i++) begin
            case (m)
                2'b00:   r[i] = fx[i] | fy[i];
                2'b01:   r[i] = fx[i] & fy[i];
                2'b10:   r[i] = fx[i] ^ fy[i];
                default: r[i] = ~fx[i];
            endcase
        end
        return r;
    endfunction

    function automatic logic [N-1:0] to_2state(input logic [N-1:0] r);
        logic [N-1:0] c;
        for (int i = 0; i < N; i++) c[i] = (r[i] === 1'b1) ? 1'b1 : 1'b0;
        return c;
    endfunction

    // Scoreboard: inputs and handshakes are stable at the falling edge, so both the pop
    // and the accept about to happen at the next rising edge are decided here.
    always @(negedge clk) begin
        logic [N-1:0] r, c, e;
        if (rst_n) begin
            if (out_valid && out_ready) begin
                cmp_count++;
                if (exp_q.size() == 0) begin
                    fail_count++;
                    $display("FAIL pop_unexpected got %h required no output", out_data);
                end else begin
                    e = exp_q.pop_front();
                    if (out_data !== e) begin
                        fail_count++;
                        $display("FAIL out_data got %h required %h", out_data, e);
                    end
                end
            end
            if (in_valid && in_ready) begin
                r = raw_of(mode_i, a_i, b_i);
                c = to_2state(r);
                exp_q.push_back(c);
                m_hist = {m_hist[DEPTH*N-N-1:0], c};
                if ($isunknown(r)) begin
                    m_xz_seen = 1'b1;
                    if (m_xz_count != {CNT_W{1'b1}}) m_xz_count = m_xz_count + 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        exp_q.delete();
        m_hist     = '0;
        m_xz_count = '0;
        m_xz_seen  = 1'b0;
    endtask

    // Drives one beat and holds it until accepted; returns 1 ns after the accepting edge.
    task automatic send(input logic [1:0] m, input vec_t x, input vec_t y);
        bit ok;
        int n;
        mode_i = m; a_i = x; b_i = y; in_valid = 1'b1;
        ok = 1'b0; n = 0;
        while (!ok && n < 20) begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end
        in_valid = 1'b0;
        cmp_count++;
        if (!ok) begin
            fail_count++;
            $display("FAIL send_timeout in_ready got %b required 1 within 20 cycles", in_ready);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #12;
        cmp_count++;
        if (out_valid !== 1'b0 || out_data !== '0 || hist !== '0 || xz_count !== '0 || xz_seen !== 1'b0) begin
            fail_count++;
            $display("FAIL reset_outputs got v=%b d=%h h=%h c=%h s=%b required all 0",
                     out_valid, out_data, hist, xz_count, xz_seen);
        end
        model_clear();
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        cmp_count++;
        if (in_ready !== 1'b1) begin
            fail_count++;
            $display("FAIL reset_in_ready got %b required 1", in_ready);
        end
    endtask

    task automatic test_single();
        vec_t pa, pb, ones;
        pa = {CHANNELS{2'b01}};
        pb = {CHANNELS{2'b10}};
        ones = {CHANNELS{2'b11}};
        out_ready = 1'b1;
        send(2'b00, pa, pb);
        cmp_count++;
        if (out_valid !== 1'b1 || out_data !== ones) begin
            fail_count++;
            $display("FAIL single_latency got v=%b d=%h required v=1 d=%h", out_valid, out_data, ones);
        end
        cmp_count++;
        if (hist[0] !== ones || xz_count !== '0) begin
            fail_count++;
            $display("FAIL single_hist got h0=%h c=%h required h0=%h c=0", hist[0], xz_count, ones);
        end
        tick();
        cmp_count++;
        if (out_valid !== 1'b0) begin
            fail_count++;
            $display("FAIL single_drain got out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_x_inject();
        vec_t pa, pb, clean;
        logic [N-1:0] h0;
        pa = '0; pb = '0;
        pa[0] = 2'b1x;
        pb[0] = 2'b11;
        out_ready = 1'b1;
        send(2'b01, pa, pb);
        h0 = m_hist[N-1:0];
        cmp_count++;
        if (out_data !== h0 || hist[0] !== h0) begin
            fail_count++;
            $display("FAIL x_convert got d=%h h0=%h required %h", out_data, hist[0], h0);
        end
        cmp_count++;
        if (out_data[0] !== 2'b10) begin
            fail_count++;
            $display("FAIL x_chan0 got %b required 10", out_data[0]);
        end
        cmp_count++;
        if (xz_count !== m_xz_count || xz_seen !== m_xz_seen) begin
            fail_count++;
            $display("FAIL x_count got c=%0d s=%b required c=%0d s=%b", xz_count, xz_seen, m_xz_count, m_xz_seen);
        end
        clean = {CHANNELS{2'b11}};
        send(2'b01, clean, clean);
        cmp_count++;
        if (xz_count !== m_xz_count || xz_seen !== m_xz_seen || out_data !== clean) begin
            fail_count++;
            $display("FAIL x_clean got c=%0d s=%b d=%h required c=%0d s=%b d=%h",
                     xz_count, xz_seen, out_data, m_xz_count, m_xz_seen, clean);
        end
        tick();
    endtask

    task automatic test_backpressure();
        vec_t p0, p1, p2;
        p0 = {2'b00, 2'b01, 2'b10};
        p1 = {2'b11, 2'b00, 2'b01};
        p2 = {2'b10, 2'b11, 2'b00};
        out_ready = 1'b0;
        mode_i = 2'b10; b_i = '0; in_valid = 1'b1;
        a_i = p0; tick();
        cmp_count++;
        if (in_ready !== 1'b1 || out_data !== p0) begin
            fail_count++;
            $display("FAIL bp_first got rdy=%b d=%h required rdy=1 d=%h", in_ready, out_data, p0);
        end
        a_i = p1; tick();
        cmp_count++;
        if (in_ready !== 1'b0) begin
            fail_count++;
            $display("FAIL bp_full got in_ready=%b required 0", in_ready);
        end
        a_i = p2;
        for (int k = 0; k < 2; k++) begin
            tick();
            cmp_count++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== p0) begin
                fail_count++;
                $display("FAIL bp_hold got rdy=%b v=%b d=%h required rdy=0 v=1 d=%h",
                         in_ready, out_valid, out_data, p0);
            end
        end
        out_ready = 1'b1;
        tick();
        cmp_count++;
        if (in_ready !== 1'b1 || out_data !== p1) begin
            fail_count++;
            $display("FAIL bp_release got rdy=%b d=%h required rdy=1 d=%h", in_ready, out_data, p1);
        end
        tick();
        in_valid = 1'b0;
        cmp_count++;
        if (out_valid !== 1'b1 || out_data !== p2) begin
            fail_count++;
            $display("FAIL bp_third got v=%b d=%h required v=1 d=%h", out_valid, out_data, p2);
        end
        tick();
        tick();
        cmp_count++;
        if (exp_q.size() != 0 || out_valid !== 1'b0) begin
            fail_count++;
            $display("FAIL bp_drain got pending=%0d v=%b required 0 0", exp_q.size(), out_valid);
        end
    endtask

    task automatic test_hist_wrap();
        vec_t pats[5];
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            for (int ch = 0; ch < CHANNELS; ch++) pats[k][ch] = 2'((ch + k) % 4);
            send(2'b11, pats[k], '1);
        end
        cmp_count++;
        if (hist[0] !== ~pats[4] || hist[3] !== ~pats[1] || hist[1] !== ~pats[3]) begin
            fail_count++;
            $display("FAIL hist_wrap got %h required h0=%h h1=%h h3=%h", hist, ~pats[4], ~pats[3], ~pats[1]);
        end
        cmp_count++;
        if (hist !== m_hist) begin
            fail_count++;
            $display("FAIL hist_model got %h required %h", hist, m_hist);
        end
        tick();
    endtask

    task automatic test_saturation();
        vec_t pa;
        out_ready = 1'b1;
        for (int k = 0; k < 6; k++) begin
            pa = vec_t'(k);
            pa[1] = 2'bz1;
            send(2'b10, pa, '0);
            cmp_count++;
            if (xz_count !== m_xz_count || xz_seen !== m_xz_seen) begin
                fail_count++;
                $display("FAIL sat_step%0d got c=%0d s=%b required c=%0d s=%b",
                         k, xz_count, xz_seen, m_xz_count, m_xz_seen);
            end
        end
        tick();
    endtask

    task automatic test_async_reset();
        vec_t cold;
        out_ready = 1'b0;
        send(2'b00, {CHANNELS{2'b01}}, '0);
        send(2'b10, {CHANNELS{2'bx1}}, '0);
        cmp_count++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            fail_count++;
            $display("FAIL ar_prefill got v=%b rdy=%b required v=1 rdy=0", out_valid, in_ready);
        end
        #2;
        rst_n = 1'b0;
        #1;
        cmp_count++;
        if (out_valid !== 1'b0 || hist !== '0 || xz_count !== '0 || xz_seen !== 1'b0 || out_data !== '0) begin
            fail_count++;
            $display("FAIL ar_clear got v=%b h=%h c=%0d s=%b d=%h required all 0",
                     out_valid, hist, xz_count, xz_seen, out_data);
        end
        model_clear();
        #2;
        rst_n = 1'b1;
        tick();
        cmp_count++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fail_count++;
            $display("FAIL ar_release got rdy=%b v=%b required rdy=1 v=0", in_ready, out_valid);
        end
        out_ready = 1'b1;
        cold = {2'b10, 2'b01, 2'b11};
        send(2'b01, cold, '1);
        cmp_count++;
        if (out_valid !== 1'b1 || out_data !== cold || hist !== {{(DEPTH-1)*N{1'b0}}, cold}) begin
            fail_count++;
            $display("FAIL ar_cold got v=%b d=%h h=%h required v=1 d=%h", out_valid, out_data, hist, cold);
        end
        tick();
    endtask

    task automatic test_back_to_back();
        bit acc;
        in_valid = 1'b0;
        for (int k = 0; k < 40; k++) begin
            if (!in_valid && $urandom_range(0, 3) != 0) begin
                in_valid = 1'b1;
                mode_i = 2'($urandom_range(0, 3));
                a_i = vec_t'($urandom_range(0, (1 << N) - 1));
                b_i = vec_t'($urandom_range(0, (1 << N) - 1));
            end
            out_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            acc = in_valid && in_ready;
            tick();
            if (acc) in_valid = 1'b0;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 4; k++) tick();
        cmp_count++;
        if (exp_q.size() != 0 || hist !== m_hist || xz_count !== m_xz_count) begin
            fail_count++;
            $display("FAIL b2b_final got pending=%0d h=%h c=%0d required 0 h=%h c=%0d",
                     exp_q.size(), hist, xz_count, m_hist, m_xz_count);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_x_inject();
        test_backpressure();
        test_hist_wrap();
        test_saturation();
        test_async_reset();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, fail_count);
        $finish;
    end

endmodule
